mem_access_unit: RTL and testbench

- CPU-side initiator for the 16-bit word-addressed data/instruction memory.
- Accepts instruction-fetch and load/store requests from the core and arbitrates between them.
- Drives the memory's MemRead/MemWrite/ADDR/write-data port and waits out the read latency.
- Returns read data or write completion to the requester, with a one-entry pending buffer per requester and out-of-range address checking.

---
 rtl/mem_access_unit.sv | 214 +++++++++++++++++++++
 tb/tb_mem_access_unit.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// ==== mem_access_unit: fetch / load-store arbiter and memory initiator ====
// Rev 1.0 - initial release
`default_nettype none

module mem_access_unit #(
   parameter int ADDR_W       = 16,
   parameter int DATA_W       = 16,
   parameter int MEM_DEPTH    = 1024,
   parameter int READ_LATENCY = 1
) (
   input  logic              CLK,
   input  logic              reset,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic              if_valid,
   output logic [DATA_W-1:0] if_data,
   output logic              if_err,
   input  logic              ls_req,
   input  logic              ls_we,
   input  logic [ADDR_W-1:0] ls_addr,
   input  logic [DATA_W-1:0] ls_wdata,
   output logic              ls_valid,
   output logic [DATA_W-1:0] ls_rdata,
   output logic              ls_err,
   output logic              busy,
   output logic              ovf,
   output logic              MemRead,
   output logic              MemWrite,
   output logic [ADDR_W-1:0] ADDR,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
);

   // One extra bit so MEM_DEPTH == 2**ADDR_W still compares correctly
   localparam logic [ADDR_W:0] DEPTH_LIM = (ADDR_W+1)'(MEM_DEPTH);
   localparam logic [2:0]      LAT_LOAD  = 3'(READ_LATENCY - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } state_t;

   state_t state;
   logic [2:0] cnt;
   logic       cur_ls;
   logic       cur_we;

   logic              if_full;
   logic [ADDR_W-1:0] if_slot_addr;
   logic              ls_full;
   logic [ADDR_W-1:0] ls_slot_addr;
   logic              ls_slot_we;
   logic [DATA_W-1:0] ls_slot_wdata;

   logic idle;
   logic pick_ls_pend, pick_ls_new, pick_if_pend, pick_if_new;
   logic accept, sel_is_ls, in_range;
   logic [ADDR_W-1:0] sel_addr;
   logic              sel_we;
   logic [DATA_W-1:0] sel_wdata;
   logic ls_park, ls_room, if_park, if_room;

   assign idle         = (state == IDLE);
   assign pick_ls_pend = idle & ls_full;
   assign pick_ls_new  = idle & ~ls_full & ls_req;
   assign pick_if_pend = idle & ~ls_full & ~ls_req & if_full;
   assign pick_if_new  = idle & ~ls_full & ~ls_req & ~if_full & if_req;
   assign accept       = pick_ls_pend | pick_ls_new | pick_if_pend | pick_if_new;
   assign sel_is_ls    = pick_ls_pend | pick_ls_new;

   always_comb begin
      sel_addr  = if_addr;
      sel_we    = 1'b0;
      sel_wdata = '0;
      if (pick_ls_pend) begin
         sel_addr  = ls_slot_addr;
         sel_we    = ls_slot_we;
         sel_wdata = ls_slot_wdata;
      end else if (pick_ls_new) begin
         sel_addr  = ls_addr;
         sel_we    = ls_we;
         sel_wdata = ls_wdata;
      end else if (pick_if_pend) begin
         sel_addr  = if_slot_addr;
      end
   end

   assign in_range = ({1'b0, sel_addr} < DEPTH_LIM);

   // A strobe not accepted this edge parks in its slot; a slot being drained this edge has room
   assign ls_park = ls_req & ~pick_ls_new;
   assign ls_room = ~ls_full | pick_ls_pend;
   assign if_park = if_req & ~pick_if_new;
   assign if_room = ~if_full | pick_if_pend;

   always_ff @(posedge CLK) begin
      if (reset) begin
         ls_full       <= 1'b0;
         ls_slot_addr  <= '0;
         ls_slot_we    <= 1'b0;
         ls_slot_wdata <= '0;
         if_full       <= 1'b0;
         if_slot_addr  <= '0;
         ovf           <= 1'b0;
      end else begin
         if (ls_park && ls_room) begin
            ls_full       <= 1'b1;
            ls_slot_addr  <= ls_addr;
            ls_slot_we    <= ls_we;
            ls_slot_wdata <= ls_wdata;
         end else if (pick_ls_pend) begin
            ls_full <= 1'b0;
         end
         if (if_park && if_room) begin
            if_full      <= 1'b1;
            if_slot_addr <= if_addr;
         end else if (pick_if_pend) begin
            if_full <= 1'b0;
         end
         if ((ls_park && !ls_room) || (if_park && !if_room))
            ovf <= 1'b1;
      end
   end

   always_ff @(posedge CLK) begin
      if (reset) begin
         state     <= IDLE;
         cnt       <= '0;
         cur_ls    <= 1'b0;
         cur_we    <= 1'b0;
         MemRead   <= 1'b0;
         MemWrite  <= 1'b0;
         ADDR      <= '0;
         mem_wdata <= '0;
         if_valid  <= 1'b0;
         if_data   <= '0;
         if_err    <= 1'b0;
         ls_valid  <= 1'b0;
         ls_rdata  <= '0;
         ls_err    <= 1'b0;
      end else begin
         MemRead  <= 1'b0;
         MemWrite <= 1'b0;
         if_valid <= 1'b0;
         if_err   <= 1'b0;
         ls_valid <= 1'b0;
         ls_err   <= 1'b0;
         case (state)
            IDLE: begin
               if (accept) begin
                  cur_ls <= sel_is_ls;
                  cur_we <= sel_we;
                  if (in_range) begin
                     ADDR      <= sel_addr;
                     mem_wdata <= sel_wdata;
                     MemRead   <= ~sel_we;
                     MemWrite  <= sel_we;
                     state     <= ISSUE;
                  end else begin
                     // Out of range: nothing goes to memory, respond with an error at once
                     if (sel_is_ls) begin
                        ls_valid <= 1'b1;
                        ls_err   <= 1'b1;
                        ls_rdata <= '0;
                     end else begin
                        if_valid <= 1'b1;
                        if_err   <= 1'b1;
                        if_data  <= '0;
                     end
                     state <= RESP;
                  end
               end
            end
            ISSUE: begin
               if (cur_we) begin
                  ls_valid <= 1'b1;
                  ls_rdata <= '0;
                  state    <= RESP;
               end else begin
                  cnt   <= LAT_LOAD;
                  state <= WAIT;
               end
            end
            WAIT: begin
               if (cnt == 3'd0) begin
                  if (cur_ls) begin
                     ls_valid <= 1'b1;
                     ls_rdata <= mem_rdata;
                  end else begin
                     if_valid <= 1'b1;
                     if_data  <= mem_rdata;
                  end
                  state <= RESP;
               end else begin
                  cnt <= cnt - 3'd1;
               end
            end
            RESP: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   assign busy = (state != IDLE) | if_full | ls_full;

endmodule

`default_nettype wire

// File: tb/tb_mem_access_unit.sv
// ==== tb_mem_access_unit: scoreboard bench for mem_access_unit ====
// Rev 1.0 - initial release
`default_nettype none

module tb_mem_access_unit;

   typedef struct packed {
      logic [15:0] data;
      logic        err;
   } exp_t;

   logic        CLK;
   logic        reset;
   logic        if_req;
   logic [15:0] if_addr;
   logic        if_valid;
   logic [15:0] if_data;
   logic        if_err;
   logic        ls_req;
   logic        ls_we;
   logic [15:0] ls_addr;
   logic [15:0] ls_wdata;
   logic        ls_valid;
   logic [15:0] ls_rdata;
   logic        ls_err;
   logic        busy;
   logic        ovf;
   logic        MemRead;
   logic        MemWrite;
   logic [15:0] ADDR;
   logic [15:0] mem_wdata;
   logic [15:0] mem_rdata;

   logic        reset3;
   logic        if_req3;
   logic [15:0] if_addr3;
   logic        if_valid3;
   logic [15:0] if_data3;
   logic        if_err3;
   logic        ls_req3;
   logic        ls_we3;
   logic [15:0] ls_addr3;
   logic [15:0] ls_wdata3;
   logic        ls_valid3;
   logic [15:0] ls_rdata3;
   logic        ls_err3;
   logic        busy3;
   logic        ovf3;
   logic        MemRead3;
   logic        MemWrite3;
   logic [15:0] ADDR3;
   logic [15:0] mem_wdata3;
   logic [15:0] mem_rdata3;

   int n_checks = 0;
   int n_pass   = 0;
   int n_fail   = 0;

   exp_t ls_q[$];
   exp_t if_q[$];

   mem_access_unit #(
      .ADDR_W(16), .DATA_W(16), .MEM_DEPTH(1024), .READ_LATENCY(1)
   ) dut (
      .CLK(CLK), .reset(reset),
      .if_req(if_req), .if_addr(if_addr), .if_valid(if_valid), .if_data(if_data), .if_err(if_err),
      .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
      .ls_valid(ls_valid), .ls_rdata(ls_rdata), .ls_err(ls_err),
      .busy(busy), .ovf(ovf),
      .MemRead(MemRead), .MemWrite(MemWrite), .ADDR(ADDR),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   mem_access_unit #(
      .ADDR_W(16), .DATA_W(16), .MEM_DEPTH(1024), .READ_LATENCY(3)
   ) dut3 (
      .CLK(CLK), .reset(reset3),
      .if_req(if_req3), .if_addr(if_addr3), .if_valid(if_valid3), .if_data(if_data3), .if_err(if_err3),
      .ls_req(ls_req3), .ls_we(ls_we3), .ls_addr(ls_addr3), .ls_wdata(ls_wdata3),
      .ls_valid(ls_valid3), .ls_rdata(ls_rdata3), .ls_err(ls_err3),
      .busy(busy3), .ovf(ovf3),
      .MemRead(MemRead3), .MemWrite(MemWrite3), .ADDR(ADDR3),
      .mem_wdata(mem_wdata3), .mem_rdata(mem_rdata3)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   function automatic logic [15:0] iv(input logic [15:0] a);
      return {a[7:0], a[15:8]} ^ 16'h5A3C;
   endfunction

   // Latency-1 behavioural memory for dut
   logic [15:0] mem [0:1023];
   logic [15:0] rd1;
   always @(posedge CLK) begin
      if (MemWrite) mem[ADDR[9:0]] <= mem_wdata;
      if (MemRead)  rd1 <= mem[ADDR[9:0]];
   end
   assign mem_rdata = rd1;

   // Latency-3 read-only memory for dut3
   logic [15:0] p3 [0:2];
   always @(posedge CLK) begin
      p3[0] <= MemRead3 ? iv(ADDR3) : 16'h0000;
      p3[1] <= p3[0];
      p3[2] <= p3[1];
   end
   assign mem_rdata3 = p3[2];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) begin
         n_pass++;
      end else begin
         n_fail++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Scoreboard: pop the expected response whenever the DUT pulses a valid
   always @(negedge CLK) begin
      if (!reset) begin
         if (if_valid && ls_valid) check("both_valid", 32'(if_valid & ls_valid), 32'd0);
         if (ls_valid) begin
            if (ls_q.size() == 0) begin
               check("ls_unexpected", 32'(ls_q.size()), 32'd1);
            end else begin
               exp_t e;
               e = ls_q.pop_front();
               check("ls_rdata", 32'(ls_rdata), 32'(e.data));
               check("ls_err", 32'(ls_err), 32'(e.err));
            end
         end
         if (if_valid) begin
            if (if_q.size() == 0) begin
               check("if_unexpected", 32'(if_q.size()), 32'd1);
            end else begin
               exp_t e;
               e = if_q.pop_front();
               check("if_data", 32'(if_data), 32'(e.data));
               check("if_err", 32'(if_err), 32'(e.err));
            end
         end
      end
   end

   // Count edges from the accept edge (current negedge counts as 1) until a valid appears
   task automatic wait_any(output int cycles, output logic was_ls, output logic was_if);
      cycles = 1;
      while (!(ls_valid || if_valid) && cycles < 30) begin
         @(negedge CLK);
         cycles++;
      end
      was_ls = ls_valid;
      was_if = if_valid;
   endtask

   task automatic drain(input string tag);
      int k;
      k = 0;
      while ((busy || ls_valid || if_valid) && k < 40) begin
         @(negedge CLK);
         k++;
      end
      check({tag, "_busy"}, 32'(busy), 32'd0);
      check({tag, "_lsq"}, 32'(ls_q.size()), 32'd0);
      check({tag, "_ifq"}, 32'(if_q.size()), 32'd0);
   endtask

   task automatic ls_issue(input logic we, input logic [15:0] a, input logic [15:0] d);
      ls_req = 1'b1; ls_we = we; ls_addr = a; ls_wdata = d;
      @(negedge CLK);
      ls_req = 1'b0;
   endtask

   task automatic if_issue(input logic [15:0] a);
      if_req = 1'b1; if_addr = a;
      @(negedge CLK);
      if_req = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int   c;
      int   pulses;
      logic wl, wi;

      reset = 1'b1; reset3 = 1'b1;
      if_req = 1'b0; if_addr = '0; ls_req = 1'b0; ls_we = 1'b0; ls_addr = '0; ls_wdata = '0;
      if_req3 = 1'b0; if_addr3 = '0; ls_req3 = 1'b0; ls_we3 = 1'b0; ls_addr3 = '0; ls_wdata3 = '0;
      for (int i = 0; i < 1024; i++) mem[i] <= iv(16'(i));

      repeat (3) @(negedge CLK);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_ovf", 32'(ovf), 32'd0);
      check("rst_memrw", 32'({MemRead, MemWrite}), 32'd0);
      check("rst_valids", 32'({ls_valid, if_valid}), 32'd0);
      check("rst_addr", 32'(ADDR), 32'd0);
      check("rst_rdata", 32'(ls_rdata), 32'd0);
      reset = 1'b0; reset3 = 1'b0;

      // Store 0xBEEF to 0x0005
      ls_q.push_back({16'h0000, 1'b0});
      ls_issue(1'b1, 16'h0005, 16'hBEEF);
      check("st_memwrite", 32'(MemWrite), 32'd1);
      check("st_memread", 32'(MemRead), 32'd0);
      check("st_addr", 32'(ADDR), 32'h0005);
      check("st_wdata", 32'(mem_wdata), 32'hBEEF);
      wait_any(c, wl, wi);
      check("st_latency", 32'(c), 32'd2);
      check("st_who", 32'(wl), 32'd1);
      check("st_write_once", 32'(MemWrite), 32'd0);
      drain("st");

      // Load it back
      ls_q.push_back({16'hBEEF, 1'b0});
      ls_issue(1'b0, 16'h0005, 16'h0000);
      check("ld_memread", 32'(MemRead), 32'd1);
      check("ld_memwrite", 32'(MemWrite), 32'd0);
      check("ld_addr", 32'(ADDR), 32'h0005);
      wait_any(c, wl, wi);
      check("ld_latency", 32'(c), 32'd3);
      drain("ld");

      // Simultaneous fetch and load: load wins, fetch follows from its slot
      ls_q.push_back({iv(16'h0020), 1'b0});
      if_q.push_back({iv(16'h0010), 1'b0});
      if_req = 1'b1; if_addr = 16'h0010;
      ls_issue(1'b0, 16'h0020, 16'h0000);
      if_req = 1'b0;
      check("arb_addr", 32'(ADDR), 32'h0020);
      wait_any(c, wl, wi);
      check("arb_first_lat", 32'(c), 32'd3);
      check("arb_first_ls", 32'({wl, wi}), 32'b10);
      @(negedge CLK);
      wait_any(c, wl, wi);
      check("arb_second_gap", 32'(c), 32'd4);
      check("arb_second_if", 32'({wl, wi}), 32'b01);
      check("arb_ovf", 32'(ovf), 32'd0);
      drain("arb");

      // Two fetch strobes during a load: first buffered, second dropped
      ls_q.push_back({iv(16'h0030), 1'b0});
      if_q.push_back({iv(16'h0040), 1'b0});
      ls_issue(1'b0, 16'h0030, 16'h0000);
      if_req = 1'b1; if_addr = 16'h0040;
      @(negedge CLK);
      if_addr = 16'h0041;
      @(negedge CLK);
      if_req = 1'b0;
      check("ovf_set", 32'(ovf), 32'd1);
      drain("ovf");
      check("ovf_sticky", 32'(ovf), 32'd1);

      // Out-of-range load at exactly MEM_DEPTH
      ls_q.push_back({16'h0000, 1'b1});
      ls_issue(1'b0, 16'h0400, 16'h0000);
      check("oor_no_read", 32'({MemRead, MemWrite}), 32'd0);
      wait_any(c, wl, wi);
      check("oor_latency", 32'(c), 32'd1);
      check("oor_who", 32'(wl), 32'd1);
      @(negedge CLK);
      check("oor_err_drops", 32'(ls_err), 32'd0);
      drain("oor");

      // Last in-range word
      ls_q.push_back({iv(16'h03FF), 1'b0});
      ls_issue(1'b0, 16'h03FF, 16'h0000);
      check("top_memread", 32'(MemRead), 32'd1);
      wait_any(c, wl, wi);
      check("top_latency", 32'(c), 32'd3);
      drain("top");
      check("if_data_hold", 32'(if_data), 32'(iv(16'h0040)));

      // Out-of-range fetch at the top of the address space
      if_q.push_back({16'h0000, 1'b1});
      if_issue(16'hFFFF);
      check("ifoor_no_read", 32'(MemRead), 32'd0);
      wait_any(c, wl, wi);
      check("ifoor_latency", 32'(c), 32'd1);
      check("ifoor_who", 32'(wi), 32'd1);
      drain("ifoor");

      reset = 1'b1;
      @(negedge CLK);
      check("rst2_ovf", 32'(ovf), 32'd0);
      check("rst2_busy", 32'(busy), 32'd0);
      reset = 1'b0;

      // Latency-3 instance: reset while waiting aborts the fetch silently
      if_req3 = 1'b1; if_addr3 = 16'h0010;
      @(negedge CLK);
      if_req3 = 1'b0;
      @(negedge CLK);
      check("l3_busy_wait", 32'(busy3), 32'd1);
      reset3 = 1'b1;
      @(negedge CLK);
      check("l3_rst_busy", 32'(busy3), 32'd0);
      check("l3_rst_memread", 32'(MemRead3), 32'd0);
      check("l3_rst_ovf", 32'(ovf3), 32'd0);
      reset3 = 1'b0;
      pulses = 0;
      for (int i = 0; i < 10; i++) begin
         if (if_valid3) pulses++;
         @(negedge CLK);
      end
      check("l3_no_valid", 32'(pulses), 32'd0);
      if_req3 = 1'b1; if_addr3 = 16'h0022;
      @(negedge CLK);
      if_req3 = 1'b0;
      c = 1;
      while (!if_valid3 && c < 30) begin
         @(negedge CLK);
         c++;
      end
      check("l3_latency", 32'(c), 32'd5);
      check("l3_data", 32'(if_data3), 32'(iv(16'h0022)));
      check("l3_err", 32'(if_err3), 32'd0);

      repeat (2) @(negedge CLK);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

`default_nettype wire
